// File: rtl/operand_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// operand_fetch: register file with write-back bypass and one ALU output stage
// Revision: 1.0
// ---------------------------------------------------------------------------
module operand_fetch #(
   parameter int W    = 32,
   parameter int NREG = 16,
   parameter int IMMW = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    issue_valid_i,
   output logic                    issue_ready_o,
   input  logic [3:0]              issue_func_i,
   input  logic                    issue_shamt_i,
   input  logic [$clog2(NREG)-1:0] issue_rs_a_i,
   input  logic [$clog2(NREG)-1:0] issue_rs_b_i,
   input  logic                    issue_imm_en_i,
   input  logic [IMMW-1:0]         issue_imm_i,
   input  logic                    wb_en_i,
   input  logic [$clog2(NREG)-1:0] wb_addr_i,
   input  logic [W-1:0]            wb_data_i,
   output logic [W-1:0]            alu_in1_o,
   output logic [W-1:0]            alu_in2_o,
   output logic [3:0]              alu_func_o,
   output logic                    alu_shamt_o,
   output logic                    alu_valid_o,
   input  logic                    alu_ready_i
);

   localparam int AW = $clog2(NREG);

   logic [W-1:0] rf_q [NREG];

   logic [W-1:0] alu_in1_q, alu_in1_d;
   logic [W-1:0] alu_in2_q, alu_in2_d;
   logic [3:0]   alu_func_q, alu_func_d;
   logic         alu_shamt_q, alu_shamt_d;
   logic         alu_valid_q, alu_valid_d;

   logic         w_accept;
   logic [W-1:0] w_op_a;
   logic [W-1:0] w_op_b;
   logic [W-1:0] w_rs_b_val;
   logic [W-1:0] w_imm_ext;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
      end else if (wb_en_i && (wb_addr_i != '0)) begin
         rf_q[wb_addr_i] <= wb_data_i;
      end
   end

   // Register 0 is hardwired to zero and never takes the bypass.
   always_comb begin
      w_op_a = '0;
      if (issue_rs_a_i != '0) begin
         if (wb_en_i && (wb_addr_i == issue_rs_a_i)) begin
            w_op_a = wb_data_i;
         end else begin
            w_op_a = rf_q[issue_rs_a_i];
         end
      end
   end

   always_comb begin
      w_rs_b_val = '0;
      if (issue_rs_b_i != '0) begin
         if (wb_en_i && (wb_addr_i == issue_rs_b_i)) begin
            w_rs_b_val = wb_data_i;
         end else begin
            w_rs_b_val = rf_q[issue_rs_b_i];
         end
      end
   end

   assign w_imm_ext = {{(W-IMMW){issue_imm_i[IMMW-1]}}, issue_imm_i};
   assign w_op_b    = issue_imm_en_i ? w_imm_ext : w_rs_b_val;

   assign issue_ready_o = !alu_valid_q || alu_ready_i;
   assign w_accept      = issue_valid_i && issue_ready_o;

   always_comb begin
      alu_in1_d   = alu_in1_q;
      alu_in2_d   = alu_in2_q;
      alu_func_d  = alu_func_q;
      alu_shamt_d = alu_shamt_q;
      alu_valid_d = alu_valid_q;
      if (w_accept) begin
         alu_in1_d   = w_op_a;
         alu_in2_d   = w_op_b;
         alu_func_d  = issue_func_i;
         alu_shamt_d = issue_shamt_i;
         alu_valid_d = 1'b1;
      end else if (alu_ready_i) begin
         // Consumed with nothing new: drop valid, keep data as-is.
         alu_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         alu_in1_q   <= '0;
         alu_in2_q   <= '0;
         alu_func_q  <= '0;
         alu_shamt_q <= 1'b0;
         alu_valid_q <= 1'b0;
      end else begin
         alu_in1_q   <= alu_in1_d;
         alu_in2_q   <= alu_in2_d;
         alu_func_q  <= alu_func_d;
         alu_shamt_q <= alu_shamt_d;
         alu_valid_q <= alu_valid_d;
      end
   end

   assign alu_in1_o   = alu_in1_q;
   assign alu_in2_o   = alu_in2_q;
   assign alu_func_o  = alu_func_q;
   assign alu_shamt_o = alu_shamt_q;
   assign alu_valid_o = alu_valid_q;

   logic w_unused;
   assign w_unused = &{1'b0, AW[0]};

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// Testbench for operand_fetch: scoreboard of expected operands plus per-scenario checks.
module tb_operand_fetch;

   localparam int W    = 32;
   localparam int NREG = 16;
   localparam int IMMW = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            issue_valid = 1'b0;
   logic            issue_ready;
   logic [3:0]      issue_func = '0;
   logic            issue_shamt = 1'b0;
   logic [3:0]      issue_rs_a = '0;
   logic [3:0]      issue_rs_b = '0;
   logic            issue_imm_en = 1'b0;
   logic [IMMW-1:0] issue_imm = '0;
   logic            wb_en = 1'b0;
   logic [3:0]      wb_addr = '0;
   logic [W-1:0]    wb_data = '0;
   logic [W-1:0]    alu_in1;
   logic [W-1:0]    alu_in2;
   logic [3:0]      alu_func;
   logic            alu_shamt;
   logic            alu_valid;
   logic            alu_ready = 1'b0;

   int total = 0;
   int bad   = 0;

   logic [W-1:0]     model_rf [NREG];
   logic [2*W+4:0]   sb_q [$];

   always #5 clk = ~clk;

   operand_fetch #(.W(W), .NREG(NREG), .IMMW(IMMW)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
      .issue_func_i(issue_func), .issue_shamt_i(issue_shamt),
      .issue_rs_a_i(issue_rs_a), .issue_rs_b_i(issue_rs_b),
      .issue_imm_en_i(issue_imm_en), .issue_imm_i(issue_imm),
      .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
      .alu_in1_o(alu_in1), .alu_in2_o(alu_in2),
      .alu_func_o(alu_func), .alu_shamt_o(alu_shamt),
      .alu_valid_o(alu_valid), .alu_ready_i(alu_ready)
   );

   function automatic logic [W-1:0] model_read(input logic [3:0] r);
      if (r == 4'd0) return '0;
      if (wb_en && wb_addr == r) return wb_data;
      return model_rf[r];
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) model_rf[i] = '0;
      end else if (wb_en && wb_addr != 4'd0) begin
         model_rf[wb_addr] = wb_data;
      end
   end

   // Scoreboard: pop on transfer to the ALU, push on accept.
   always @(negedge clk) begin
      logic [2*W+4:0] exp_v;
      logic [W-1:0]   b;
      if (!rst_n) begin
         sb_q.delete();
      end else begin
         if (alu_valid && alu_ready) begin
            total++;
            if (sb_q.size() == 0) begin
               bad++;
               $display("FAIL sb_underflow: got in1=%0d in2=%0d func=%0d with no expected entry",
                        $signed(alu_in1), $signed(alu_in2), alu_func);
            end else begin
               exp_v = sb_q.pop_front();
               if ({alu_in1, alu_in2, alu_func, alu_shamt} !== exp_v) begin
                  bad++;
                  $display("FAIL sb_data: got in1=%0d in2=%0d func=%0d shamt=%0d exp in1=%0d in2=%0d func=%0d shamt=%0d",
                           $signed(alu_in1), $signed(alu_in2), alu_func, alu_shamt,
                           $signed(exp_v[2*W+4:W+5]), $signed(exp_v[W+4:5]), exp_v[4:1], exp_v[0]);
               end
            end
         end
         if (issue_valid && issue_ready) begin
            b = issue_imm_en ? {{(W-IMMW){issue_imm[IMMW-1]}}, issue_imm} : model_read(issue_rs_b);
            sb_q.push_back({model_read(issue_rs_a), b, issue_func, issue_shamt});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_wb(input logic en, input logic [3:0] a, input logic [W-1:0] d);
      wb_en = en; wb_addr = a; wb_data = d;
   endtask

   task automatic drive_issue(input logic [3:0] ra, input logic [3:0] rb, input logic ie,
                              input logic [IMMW-1:0] imm, input logic [3:0] f, input logic sh);
      issue_valid = 1'b1; issue_rs_a = ra; issue_rs_b = rb;
      issue_imm_en = ie; issue_imm = imm; issue_func = f; issue_shamt = sh;
   endtask

   task automatic idle();
      issue_valid = 1'b0; issue_imm_en = 1'b0; wb_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; idle(); tick(); tick();
      total++;
      if ({alu_valid, alu_in1, alu_in2, alu_func, alu_shamt} !== '0 || issue_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_state: valid=%b in1=%0d in2=%0d func=%0d shamt=%b ready=%b exp all 0, ready=1",
                  alu_valid, alu_in1, alu_in2, alu_func, alu_shamt, issue_ready);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      alu_ready = 1'b1;
      drive_wb(1'b1, 4'd3, -32'sd123); tick();
      drive_wb(1'b1, 4'd5, 32'sd456);  tick();
      wb_en = 1'b0;
      drive_issue(4'd3, 4'd5, 1'b0, '0, 4'd0, 1'b0); tick();
      idle();
      total++;
      if (alu_valid !== 1'b1 || alu_in1 !== -32'sd123 || alu_in2 !== 32'sd456 || alu_func !== 4'd0) begin
         bad++;
         $display("FAIL basic_fetch: valid=%b in1=%0d in2=%0d func=%0d exp 1 -123 456 0",
                  alu_valid, $signed(alu_in1), $signed(alu_in2), alu_func);
      end
      tick();
   endtask

   task automatic test_bypass();
      drive_wb(1'b1, 4'd3, 32'd7);  tick();
      drive_wb(1'b1, 4'd0, 32'd55); tick();
      drive_wb(1'b1, 4'd3, 32'd99);
      drive_issue(4'd3, 4'd0, 1'b0, '0, 4'd1, 1'b0); tick();
      drive_wb(1'b1, 4'd0, 32'd55);
      total++;
      if (alu_in1 !== 32'd99 || alu_in2 !== 32'd0) begin
         bad++;
         $display("FAIL bypass: in1=%0d in2=%0d exp 99 0", alu_in1, alu_in2);
      end
      drive_issue(4'd0, 4'd0, 1'b0, '0, 4'd2, 1'b0); tick();
      idle();
      total++;
      if (alu_in1 !== 32'd0 || alu_in2 !== 32'd0) begin
         bad++;
         $display("FAIL r0_read: in1=%0d in2=%0d exp 0 0", alu_in1, alu_in2);
      end
      drive_issue(4'd3, 4'd3, 1'b0, '0, 4'd3, 1'b0); tick();
      idle();
      total++;
      if (alu_in1 !== 32'd99) begin
         bad++;
         $display("FAIL bypass_stored: in1=%0d exp 99", alu_in1);
      end
      tick();
   endtask

   task automatic test_immediate();
      drive_wb(1'b1, 4'd3, 32'd123); tick();
      wb_en = 1'b0;
      drive_issue(4'd3, 4'd5, 1'b1, 16'hFFFF, 4'd6, 1'b1); tick();
      drive_issue(4'd0, 4'd5, 1'b1, 16'h7FFF, 4'd7, 1'b0);
      total++;
      if (alu_in1 !== 32'd123 || alu_in2 !== 32'hFFFF_FFFF || alu_func !== 4'd6 || alu_shamt !== 1'b1) begin
         bad++;
         $display("FAIL immediate: in1=%0d in2=%0d func=%0d shamt=%b exp 123 -1 6 1",
                  $signed(alu_in1), $signed(alu_in2), alu_func, alu_shamt);
      end
      tick();
      idle();
      total++;
      if (alu_in2 !== 32'd32767) begin
         bad++;
         $display("FAIL imm_positive: in2=%0d exp 32767", $signed(alu_in2));
      end
      tick();
   endtask

   task automatic test_backpressure();
      alu_ready = 1'b1;
      drive_issue(4'd3, 4'd5, 1'b0, '0, 4'd2, 1'b0); tick();
      alu_ready = 1'b0;
      drive_issue(4'd3, 4'd0, 1'b1, 16'h0010, 4'd9, 1'b1);
      drive_wb(1'b1, 4'd3, 32'd1000);
      #1;
      for (int k = 0; k < 3; k++) begin
         total++;
         if (issue_ready !== 1'b0 || alu_valid !== 1'b1 || alu_in1 !== 32'd123 ||
             alu_in2 !== 32'd456 || alu_func !== 4'd2 || alu_shamt !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold[%0d]: ready=%b valid=%b in1=%0d in2=%0d func=%0d exp 0 1 123 456 2",
                     k, issue_ready, alu_valid, alu_in1, alu_in2, alu_func);
         end
         tick();
         wb_en = 1'b0;
      end
      alu_ready = 1'b1;
      #1;
      total++;
      if (issue_ready !== 1'b1) begin
         bad++;
         $display("FAIL ready_release: ready=%b exp 1", issue_ready);
      end
      tick();
      idle();
      total++;
      if (alu_valid !== 1'b1 || alu_func !== 4'd9 || alu_in1 !== 32'd1000 || alu_in2 !== 32'd16) begin
         bad++;
         $display("FAIL no_bubble: valid=%b func=%0d in1=%0d in2=%0d exp 1 9 1000 16",
                  alu_valid, alu_func, alu_in1, alu_in2);
      end
      tick();
      total++;
      if (alu_valid !== 1'b0 || alu_func !== 4'd9 || alu_in1 !== 32'd1000) begin
         bad++;
         $display("FAIL drain_hold: valid=%b func=%0d in1=%0d exp 0 9 1000", alu_valid, alu_func, alu_in1);
      end
   endtask

   task automatic test_back_to_back();
      alu_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive_wb(1'b1, 4'(6 + i), 32'(1000 * (i + 1) + 7)); tick();
      end
      wb_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_issue(4'(6 + i), 4'(9 - i), 1'b0, '0, 4'(12 + i), i[0]); tick();
         total++;
         if (alu_valid !== 1'b1 || alu_func !== 4'(12 + i) || alu_in1 !== 32'(1000 * (i + 1) + 7)) begin
            bad++;
            $display("FAIL b2b[%0d]: valid=%b func=%0d in1=%0d exp 1 %0d %0d",
                     i, alu_valid, alu_func, alu_in1, 12 + i, 1000 * (i + 1) + 7);
         end
      end
      idle();
      tick();
   endtask

   task automatic test_reset_mid();
      alu_ready = 1'b0;
      drive_issue(4'd5, 4'd5, 1'b0, '0, 4'd4, 1'b1); tick();
      rst_n = 1'b0;
      drive_wb(1'b1, 4'd5, 32'd777);
      tick();
      rst_n = 1'b1;
      idle();
      #1;
      total++;
      if ({alu_valid, alu_in1, alu_in2, alu_func, alu_shamt} !== '0 || issue_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_mid: valid=%b in1=%0d in2=%0d func=%0d shamt=%b ready=%b exp all 0, ready=1",
                  alu_valid, alu_in1, alu_in2, alu_func, alu_shamt, issue_ready);
      end
      alu_ready = 1'b1;
      drive_issue(4'd5, 4'd5, 1'b0, '0, 4'd1, 1'b0); tick();
      idle();
      total++;
      if (alu_valid !== 1'b1 || alu_in1 !== 32'd0 || alu_in2 !== 32'd0) begin
         bad++;
         $display("FAIL reset_rf: valid=%b in1=%0d in2=%0d exp 1 0 0", alu_valid, alu_in1, alu_in2);
      end
      tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bypass();
      test_immediate();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL sb_leftover: %0d entries remain, exp 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
